// File: rtl/lab_led_sequencer_if.sv
// Board I/O bundle for lab_led_sequencer: raw switch/button inputs and LED-side outputs.
// There is no valid/ready here: inputs are sampled every cycle, outputs are valid every cycle, and step_tick marks pattern steps.
interface lab_led_sequencer_if;
  logic [3:0] swt;
  logic       btn_mode;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step_tick;

  modport master (output swt, btn_mode, input led, mode, step_tick);
  modport slave  (input swt, btn_mode, output led, mode, step_tick);
endinterface

// File: rtl/lab_led_sequencer.sv
// Debounced 4-switch/1-button front end driving 4 LEDs as lab logic or chase/blink/count patterns.
// Define LAB_SEQ_PWM_EN to dim the LEDs with a 16-slot PWM of PWM_DUTY on-slots.
module lab_led_sequencer #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int PWM_DUTY    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lab_led_sequencer_if.slave io
);
  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    M_LOGIC = 2'd0,
    M_CHASE = 2'd1,
    M_BLINK = 2'd2,
    M_COUNT = 2'd3
  } mode_t;

  logic [4:0]      raw, sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [5];

  assign raw = {io.btn_mode, io.swt};

  // Each input flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [3:0]        s;
  logic              btn_db, btn_prev, mode_chg, term, tick;
  logic [STEP_W-1:0] pre_cnt;
  logic [3:0]        pat_q, pat_step, led_q, led_nx;
  mode_t             mode_q, mode_nx;

  assign s        = db[3:0];
  assign btn_db   = db[4];
  assign mode_chg = btn_db & ~btn_prev;
  assign term     = (pre_cnt == STEP_LAST);
  // A mode change in the terminal cycle suppresses the step.
  assign tick     = term & ~mode_chg;
  assign mode_nx  = mode_t'(mode_q + 2'd1);

  always_comb begin
    pat_step = pat_q;
    case (mode_q)
      M_CHASE: pat_step = s[0] ? {pat_q[0], pat_q[3:1]} : {pat_q[2:0], pat_q[3]};
      M_BLINK: pat_step = {3'b000, ~pat_q[0]};
      M_COUNT: pat_step = s[3] ? pat_q : pat_q + 4'd1;
      default: pat_step = pat_q;
    endcase
  end

  // BLINK keeps only a phase bit so the on-phase tracks the live switches.
  always_comb begin
    led_nx = 4'b0000;
    case (mode_q)
      M_LOGIC: led_nx = {s[0] ^ s[1], s[2] | s[3], s[1] & ~s[2], ~s[0]};
      M_CHASE: led_nx = pat_q;
      M_BLINK: led_nx = pat_q[0] ? s : 4'b0000;
      M_COUNT: led_nx = pat_q;
      default: led_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= 1'b0;
      mode_q   <= M_LOGIC;
      pre_cnt  <= '0;
      pat_q    <= 4'b0000;
      led_q    <= 4'b0000;
    end else begin
      btn_prev <= btn_db;
      led_q    <= led_nx;
      if (mode_chg) begin
        mode_q  <= mode_nx;
        pre_cnt <= '0;
        pat_q   <= (mode_nx == M_CHASE) ? 4'b0001 : 4'b0000;
      end else begin
        pre_cnt <= term ? '0 : pre_cnt + STEP_W'(1);
        if (tick) pat_q <= pat_step;
      end
    end
  end

  assign io.mode      = mode_q;
  assign io.step_tick = tick;

`ifdef LAB_SEQ_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign io.led = led_q & {4{({1'b0, pwm_cnt} < 5'(PWM_DUTY))}};
`else
  logic [4:0] unused_pwm_duty;
  assign unused_pwm_duty = 5'(PWM_DUTY);
  assign io.led          = led_q;
`endif
endmodule

// File: tb/tb_lab_led_sequencer.sv
// Directed bench for lab_led_sequencer (DB_CYCLES=4, STEP_CYCLES=8): the driver schedules
// expected outputs against absolute cycle numbers; a negedge monitor pops and compares them.
module tb_lab_led_sequencer;
  localparam int EW = 50;
  localparam logic [2:0] M_LED = 3'b100, M_MODE = 3'b010, M_TICK = 3'b001, M_ALL = 3'b111;
  localparam int T_RESET = 0, T_PRE = 1, T_LOGIC = 2, T_DB = 3, T_CHASE = 4;
  localparam int T_BLINK = 5, T_CORNER = 6, T_COUNT = 7, T_ARST = 8;
  localparam int N = 60, B = 180, P = 220, Q = 400, R = 420;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] keep_q[$];
  logic [3:0] chase_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  lab_led_sequencer_if io();

  lab_led_sequencer #(.DB_CYCLES(4), .STEP_CYCLES(8), .PWM_DUTY(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tag_name(int t);
    case (t)
      T_RESET:  return "reset";
      T_PRE:    return "prescaler";
      T_LOGIC:  return "logic";
      T_DB:     return "debounce";
      T_CHASE:  return "chase";
      T_BLINK:  return "blink";
      T_CORNER: return "corner";
      T_COUNT:  return "count";
      default:  return "async_reset";
    endcase
  endfunction

  // driver tasks
  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(int c, int tag, logic [2:0] m, logic [3:0] l, logic [1:0] md, logic t);
    exp_q.push_back({32'(c), 8'(tag), m, l, md, t});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            ec;
    logic [2:0]    em;
    keep_q = {};
    foreach (exp_q[i]) begin
      e  = exp_q[i];
      ec = int'(e[49:18]);
      em = e[9:7];
      if (ec == cyc) begin
        checks++;
        if ((em[2] && io.led !== e[6:3]) || (em[1] && io.mode !== e[2:1]) ||
            (em[0] && io.step_tick !== e[0])) begin
          errors++;
          $display("FAIL %s cycle %0d: got led=%b mode=%0d tick=%b, expected led=%b mode=%0d tick=%b (fields %b)",
                   tag_name(int'(e[17:10])), cyc, io.led, io.mode, io.step_tick,
                   e[6:3], e[2:1], e[0], em);
        end
      end else if (ec < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale: expectation for cycle %0d never compared (now %0d)",
                 tag_name(int'(e[17:10])), ec, cyc);
      end else begin
        keep_q.push_back(e);
      end
    end
    exp_q = keep_q;
  end

  initial begin
    rst_n       = 1'b0;
    io.swt      = 4'b0000;
    io.btn_mode = 1'b0;

    // reset and release
    wait_until(2);
    expect_at(2, T_RESET, M_ALL, 4'b0000, 2'd0, 1'b0);
    wait_until(3);
    rst_n = 1'b1;
    expect_at(3, T_RESET, M_LED, 4'b0000, 2'd0, 1'b0);
    expect_at(4, T_RESET, M_LED | M_MODE, 4'b0001, 2'd0, 1'b0);
    expect_at(9, T_PRE, M_TICK, 4'b0000, 2'd0, 1'b0);
    expect_at(10, T_PRE, M_TICK, 4'b0000, 2'd0, 1'b1);
    expect_at(18, T_PRE, M_TICK, 4'b0000, 2'd0, 1'b1);

    // LOGIC mode
    wait_until(5);
    io.swt = 4'b0011;
    expect_at(11, T_LOGIC, M_LED, 4'b0001, 2'd0, 1'b0);
    expect_at(12, T_LOGIC, M_LED, 4'b0010, 2'd0, 1'b0);
    wait_until(15);
    io.swt = 4'b0101;
    expect_at(21, T_LOGIC, M_LED, 4'b0010, 2'd0, 1'b0);
    expect_at(22, T_LOGIC, M_LED, 4'b1100, 2'd0, 1'b0);

    // short pulses are rejected
    wait_until(25);
    io.swt = 4'b0100;
    wait_until(28);
    io.swt = 4'b0101;
    expect_at(32, T_DB, M_LED, 4'b1100, 2'd0, 1'b0);
    expect_at(36, T_DB, M_LED, 4'b1100, 2'd0, 1'b0);
    wait_until(40);
    io.btn_mode = 1'b1;
    wait_until(43);
    io.btn_mode = 1'b0;
    expect_at(47, T_DB, M_MODE, 4'b0000, 2'd0, 1'b0);
    expect_at(50, T_DB, M_MODE, 4'b0000, 2'd0, 1'b0);
    wait_until(50);
    io.swt = 4'b0000;
    expect_at(56, T_LOGIC, M_LED, 4'b1100, 2'd0, 1'b0);
    expect_at(57, T_LOGIC, M_LED, 4'b0001, 2'd0, 1'b0);

    // CHASE, button held 100 cycles
    wait_until(N);
    io.btn_mode = 1'b1;
    expect_at(N + 6, T_CHASE, M_MODE, 4'b0000, 2'd0, 1'b0);
    expect_at(N + 7, T_CHASE, M_MODE, 4'b0000, 2'd1, 1'b0);
    expect_at(N + 8, T_CHASE, M_LED | M_MODE, 4'b0001, 2'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      expect_at(N + 5 + 8 * k, T_CHASE, M_TICK, 4'b0000, 2'd1, 1'b0);
      expect_at(N + 6 + 8 * k, T_CHASE, M_TICK, 4'b0000, 2'd1, 1'b1);
      expect_at(N + 8 + 8 * k, T_CHASE, M_LED, chase_l[k-1], 2'd1, 1'b0);
    end
    wait_until(N + 41);
    io.swt = 4'b0001;
    expect_at(N + 48, T_CHASE, M_LED, 4'b0010, 2'd1, 1'b0);
    expect_at(N + 56, T_CHASE, M_LED, 4'b0001, 2'd1, 1'b0);
    expect_at(N + 62, T_CHASE, M_TICK, 4'b0000, 2'd1, 1'b1);
    expect_at(N + 64, T_CHASE, M_LED, 4'b1000, 2'd1, 1'b0);
    expect_at(N + 72, T_CHASE, M_LED, 4'b0100, 2'd1, 1'b0);
    wait_until(N + 100);
    expect_at(N + 100, T_DB, M_MODE, 4'b0000, 2'd1, 1'b0);
    io.btn_mode = 1'b0;
    expect_at(N + 115, T_DB, M_MODE, 4'b0000, 2'd1, 1'b0);

    // BLINK with swt=1010
    wait_until(B - 10);
    io.swt = 4'b1010;
    wait_until(B);
    io.btn_mode = 1'b1;
    expect_at(B + 7, T_BLINK, M_MODE, 4'b0000, 2'd2, 1'b0);
    expect_at(B + 8, T_BLINK, M_LED, 4'b0000, 2'd2, 1'b0);
    expect_at(B + 16, T_BLINK, M_LED, 4'b1010, 2'd2, 1'b0);
    expect_at(B + 24, T_BLINK, M_LED, 4'b0000, 2'd2, 1'b0);
    expect_at(B + 32, T_BLINK, M_LED, 4'b1010, 2'd2, 1'b0);
    expect_at(B + 40, T_BLINK, M_LED, 4'b0000, 2'd2, 1'b0);
    wait_until(B + 10);
    io.btn_mode = 1'b0;
    wait_until(B + 33);
    io.swt = 4'b0000;

    // COUNT entered in a prescaler-terminal cycle
    wait_until(P);
    io.btn_mode = 1'b1;
    expect_at(P + 6, T_CORNER, M_MODE | M_TICK, 4'b0000, 2'd2, 1'b0);
    expect_at(P + 7, T_CORNER, M_MODE, 4'b0000, 2'd3, 1'b0);
    expect_at(P + 8, T_CORNER, M_LED | M_MODE, 4'b0000, 2'd3, 1'b0);
    expect_at(P + 13, T_CORNER, M_TICK, 4'b0000, 2'd3, 1'b0);
    expect_at(P + 14, T_CORNER, M_TICK, 4'b0000, 2'd3, 1'b1);
    for (int k = 1; k <= 17; k++)
      expect_at(P + 8 + 8 * k, T_COUNT, M_LED, 4'(k), 2'd3, 1'b0);
    wait_until(P + 10);
    io.btn_mode = 1'b0;
    wait_until(P + 145);
    io.swt = 4'b1000;
    expect_at(P + 152, T_COUNT, M_LED, 4'b0010, 2'd3, 1'b0);
    expect_at(P + 158, T_COUNT, M_TICK, 4'b0000, 2'd3, 1'b1);
    expect_at(P + 160, T_COUNT, M_LED, 4'b0010, 2'd3, 1'b0);
    expect_at(P + 168, T_COUNT, M_LED, 4'b0010, 2'd3, 1'b0);
    wait_until(P + 170);
    io.swt = 4'b0000;

    // wrap back to LOGIC, then CHASE again
    wait_until(Q);
    io.btn_mode = 1'b1;
    expect_at(Q + 6, T_LOGIC, M_MODE, 4'b0000, 2'd3, 1'b0);
    expect_at(Q + 7, T_LOGIC, M_MODE, 4'b0000, 2'd0, 1'b0);
    expect_at(Q + 8, T_LOGIC, M_LED, 4'b0001, 2'd0, 1'b0);
    wait_until(Q + 10);
    io.btn_mode = 1'b0;
    wait_until(R);
    io.btn_mode = 1'b1;
    expect_at(R + 7, T_CHASE, M_MODE, 4'b0000, 2'd1, 1'b0);
    expect_at(R + 8, T_CHASE, M_LED, 4'b0001, 2'd1, 1'b0);
    expect_at(R + 16, T_CHASE, M_LED, 4'b0010, 2'd1, 1'b0);
    expect_at(R + 24, T_CHASE, M_LED, 4'b0100, 2'd1, 1'b0);
    wait_until(R + 10);
    io.btn_mode = 1'b0;

    // asynchronous reset mid-CHASE, observed before the next clock edge
    wait_until(R + 30);
    expect_at(R + 30, T_ARST, M_LED | M_MODE, 4'b0100, 2'd1, 1'b0);
    wait_until(R + 31);
    #2;
    rst_n = 1'b0;
    expect_at(R + 31, T_ARST, M_ALL, 4'b0000, 2'd0, 1'b0);
    wait_until(R + 34);
    rst_n = 1'b1;
    expect_at(R + 35, T_ARST, M_LED | M_MODE, 4'b0001, 2'd0, 1'b0);

    // drain and report
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL drain: %0d expectations left uncompared, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
